// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipeline_pkg;

   // Hazard controller states, as stored in the state register
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_e;

   // Instruction word loaded into a pipeline register by a flush
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Default register-specifier width (32 architectural registers)
   localparam int REG_W_DEF = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller <-> datapath bundle: hazard sources in, stage enables/flushes out.
// Latency: n/a (wiring only).
// Backpressure: n/a; the enables carried here are the pipeline's backpressure.
// Ports (signals):
//   id_rs/id_rt/id_uses_rs/id_uses_rt : decode-stage source operands
//   ex_is_load/ex_rd/ex_branch_taken  : execute-stage hazard sources
//   mem_busy                          : data memory still completing its access
//   *_enable / *_flush                : capture enables and bubble inserts
interface pipeline_hazard_ctrl_if
   import pipeline_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
);
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             ex_is_load;
   logic [REG_W-1:0] ex_rd;
   logic             ex_branch_taken;
   logic             mem_busy;

   logic             pc_enable;
   logic             f_d_enable;
   logic             d_x_enable;
   logic             x_m_enable;
   logic             m_w_enable;
   logic             f_d_flush;
   logic             d_x_flush;
   logic             m_w_flush;

   // Datapath side: supplies hazard sources, consumes controls
   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt,
      output ex_is_load, ex_rd, ex_branch_taken, mem_busy,
      input  pc_enable, f_d_enable, d_x_enable, x_m_enable, m_w_enable,
      input  f_d_flush, d_x_flush, m_w_flush
   );

   // Controller side
   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt,
      input  ex_is_load, ex_rd, ex_branch_taken, mem_busy,
      output pc_enable, f_d_enable, d_x_enable, x_m_enable, m_w_enable,
      output f_d_flush, d_x_flush, m_w_flush
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
// Latency: count updates on the edge after inc is sampled.
// Backpressure: none; inc is accepted every cycle.
// Ports: clock, reset_n (async, active-low), inc, clear (sync), count.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline (load-use, branch, memory wait, watchdog).
// Latency: controls are combinational, same cycle as inputs; counters/state update on the edge.
// Backpressure: drops stage enables to freeze upstream stages; a memory wait freezes PC..x-m.
// Ports:
//   clock, reset_n        : pipeline clock, async active-low reset
//   hz (slave)            : hazard sources in, enables/flushes out
//   mem_error             : sticky watchdog fault (state ERROR)
//   stall_cycles          : saturating count of memory + load-use stall cycles
//   flush_events          : saturating count of cycles where a taken branch flushed
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32,
   parameter int REG_W   = REG_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset_n,
   pipeline_hazard_ctrl_if.slave  hz,
   output logic                   mem_error,
   output logic [CNT_W-1:0]       stall_cycles,
   output logic [CNT_W-1:0]       flush_events
);

   localparam int WAIT_W = $clog2(TIMEOUT);

   localparam logic [1:0] RUN      = ST_RUN;
   localparam logic [1:0] MEM_WAIT = ST_MEM_WAIT;
   localparam logic [1:0] ERROR    = ST_ERROR;

   logic [1:0]        state;
   logic [WAIT_W-1:0] wait_cnt;

   logic load_use;
   logic mem_stall;
   logic stall_inc;
   logic flush_inc;

   // A write to r0 never creates a dependency
   assign load_use = hz.ex_is_load && (hz.ex_rd != '0) &&
                     ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                      (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

   assign mem_stall = hz.mem_busy && (state != ERROR);
   assign mem_error = (state == ERROR);

   always_comb begin
      hz.pc_enable  = 1'b0;
      hz.f_d_enable = 1'b0;
      hz.d_x_enable = 1'b0;
      hz.x_m_enable = 1'b0;
      hz.m_w_enable = 1'b0;
      hz.f_d_flush  = 1'b0;
      hz.d_x_flush  = 1'b0;
      hz.m_w_flush  = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;

      if (!reset_n || (state == ERROR)) begin
         // pipeline fully frozen
      end else if (mem_stall) begin
         // Freeze everything up to x-m; let the memory-stage instruction
         // stay put while a bubble retires through WB.
         hz.m_w_enable = 1'b1;
         hz.m_w_flush  = 1'b1;
         stall_inc     = 1'b1;
      end else if (hz.ex_branch_taken) begin
         // Kill the two wrong-path instructions; a coincident load-use is
         // moot because its consumer is one of them.
         hz.pc_enable  = 1'b1;
         hz.f_d_enable = 1'b1;
         hz.d_x_enable = 1'b1;
         hz.x_m_enable = 1'b1;
         hz.m_w_enable = 1'b1;
         hz.f_d_flush  = 1'b1;
         hz.d_x_flush  = 1'b1;
         flush_inc     = 1'b1;
      end else if (load_use) begin
         // Hold fetch/decode one cycle and push a bubble into execute
         hz.d_x_enable = 1'b1;
         hz.d_x_flush  = 1'b1;
         hz.x_m_enable = 1'b1;
         hz.m_w_enable = 1'b1;
         stall_inc     = 1'b1;
      end else begin
         hz.pc_enable  = 1'b1;
         hz.f_d_enable = 1'b1;
         hz.d_x_enable = 1'b1;
         hz.x_m_enable = 1'b1;
         hz.m_w_enable = 1'b1;
      end
   end

   // wait_cnt holds the number of busy cycles already seen in MEM_WAIT, so
   // the TIMEOUT-th consecutive busy edge is the one that finds TIMEOUT-1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (hz.mem_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!hz.mem_busy) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  state <= ERROR;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ERROR: begin
               state <= ERROR;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (stall_inc),
      .clear   (1'b0),
      .count   (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (flush_inc),
      .clear   (1'b0),
      .count   (flush_events)
   );

endmodule
